// File: rtl/rr_burst_arbiter_if.sv
// Request/grant bundle for the five-requester round-robin arbiter.
// The arbiter connects through the slave modport; requesters use master.
interface rr_burst_arbiter_if;
  logic [4:0] req;
  logic [4:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;

  modport slave  (input req, output gnt, output gnt_id, output busy);
  modport master (output req, input gnt, input gnt_id, input busy);
endinterface

// File: rtl/rr_burst_arbiter.sv
// Five-requester round-robin arbiter with burst hold.
// The owner keeps the grant until it drops its request. Ownership then
// passes directly to the next pending requester after it, with no idle
// cycle in between. Grants are registered and one-hot.
// Optional feature: define ARB_HOLD_LIMIT_EN to preempt an owner that has
// held MAX_HOLD consecutive cycles while another requester waits.
//
// state | meaning
// IDLE  | no owner, gnt all-zero
// GRANT | one owner, index held in owner
module rr_burst_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input logic               clock,
  input logic               reset,
  rr_burst_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     st, st_nxt;
  logic [2:0] owner, owner_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] win;
  logic       found;
  logic       keep;
  logic       preempt;
  logic [4:0] req;
  logic [4:0] gnt_c;
  logic [2:0] gnt_id_c;
  logic       busy_c;

  if (MAX_HOLD < 2 || MAX_HOLD > 15 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_burst_arbiter: MAX_HOLD must be 2..15 and below 2**HOLD_W");
  end

  assign req = bus.req;

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  // First pending requester in the order ptr, ptr+1, ... (mod 5).
  // The loop runs backwards so that the lowest offset is assigned last.
  always_comb begin
    logic [3:0] sum;
    found = 1'b0;
    win   = 3'd0;
    sum   = 4'd0;
    for (int k = 4; k >= 0; k--) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'd5) sum = sum - 4'd5;
      if (req[sum[2:0]]) begin
        found = 1'b1;
        win   = sum[2:0];
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  // hold_cnt counts edges the owner has kept the grant. At this edge the
  // owner has completed hold_cnt+1 cycles, which is the value compared
  // against MAX_HOLD.
  assign preempt = (st == GRANT) && (hold_cnt >= HOLD_W'(MAX_HOLD - 1)) &&
                   (|(req & ~(5'b00001 << owner)));

  // Hold counter advances only while the same owner keeps the grant.
  always_comb begin
    hold_nxt = '0;
    if (keep) hold_nxt = (hold_cnt == HOLD_W'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
  end

  // Hold counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) hold_cnt <= '0;
    else        hold_cnt <= hold_nxt;
  end
`else
  assign preempt = 1'b0;
`endif

  assign keep = (st == GRANT) && req[owner] && !preempt;

  // State, owner and rotation pointer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st    <= IDLE;
      owner <= 3'd0;
      ptr   <= 3'd0;
    end else begin
      st    <= st_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next owner: keep, hand over to the next winner, or fall back to IDLE.
  // On a release the owner's own bit is already zero, and on a preemption
  // it sits last in the search order, so the winner is never the old owner.
  always_comb begin
    st_nxt    = st;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    case (st)
      IDLE: begin
        if (found) begin
          st_nxt    = GRANT;
          owner_nxt = win;
          ptr_nxt   = wrap_inc(win);
        end
      end
      GRANT: begin
        if (!keep) begin
          if (found) begin
            owner_nxt = win;
            ptr_nxt   = wrap_inc(win);
          end else begin
            st_nxt    = IDLE;
            owner_nxt = 3'd0;
          end
        end
      end
      default: begin
        st_nxt    = IDLE;
        owner_nxt = 3'd0;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    gnt_c    = 5'b00000;
    busy_c   = (st == GRANT);
    gnt_id_c = busy_c ? owner : 3'd0;
    if (busy_c) gnt_c[owner] = 1'b1;
  end

  assign bus.gnt    = gnt_c;
  assign bus.gnt_id = gnt_id_c;
  assign bus.busy   = busy_c;

endmodule
